hibrid_mul_pipe: RTL

HIBRID_MUL_PIPE -- requirements
Module: hibrid_mul_pipe

---
 rtl/hibrid_mul_pkg.sv | 35 +++
 rtl/hibrid_mul_pp.sv | 71 +++++++
 rtl/hibrid_mul_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hibrid_mul_pkg.sv
// ============================================================================
// Module      : hibrid_mul_pkg
// Description : Shared widths, result-width derivation and partial-product
//               width constants for the hibrid_mul_pipe multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hibrid_mul_pkg;

    localparam int A_W_DEF     = 34;
    localparam int B_W_DEF     = 32;
    localparam int A_LO_W_DEF  = 24;
    localparam int B_LO_W_DEF  = 17;
    localparam int TAG_W_DEF   = 8;
    localparam int ACC_GUARD_W = 4;

    localparam int PLL_W_DEF = A_LO_W_DEF + B_LO_W_DEF;
    localparam int PLH_W_DEF = A_LO_W_DEF + (B_W_DEF - B_LO_W_DEF);
    localparam int PHL_W_DEF = (A_W_DEF - A_LO_W_DEF) + B_LO_W_DEF;
    localparam int PHH_W_DEF = (A_W_DEF - A_LO_W_DEF) + (B_W_DEF - B_LO_W_DEF);

`ifdef HIBRID_MUL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    function automatic int res_w(input int a_w, input int b_w, input int acc_w);
        return ACC_EN ? acc_w : a_w + b_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hibrid_mul_pp.sv
// ============================================================================
// Module      : hibrid_mul_pp
// Description : Splits A/B into high/low slices and registers the four partial
//               products (low-slice products on DSP, high-slice ones in LUTs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hibrid_mul_pp
    import hibrid_mul_pkg::*;
#(
    parameter int A_W    = A_W_DEF,
    parameter int B_W    = B_W_DEF,
    parameter int A_LO_W = A_LO_W_DEF,
    parameter int B_LO_W = B_LO_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [A_W-1:0]                     a,
    input  logic [B_W-1:0]                     b,
    output logic [A_LO_W+B_LO_W-1:0]           pll,
    output logic [A_LO_W+B_W-B_LO_W-1:0]       plh,
    output logic [A_W-A_LO_W+B_LO_W-1:0]       phl,
    output logic [A_W-A_LO_W+B_W-B_LO_W-1:0]   phh
);

    localparam int A_HI_W = A_W - A_LO_W;
    localparam int B_HI_W = B_W - B_LO_W;
    localparam int PLL_W  = A_LO_W + B_LO_W;
    localparam int PLH_W  = A_LO_W + B_HI_W;
    localparam int PHL_W  = A_HI_W + B_LO_W;
    localparam int PHH_W  = A_HI_W + B_HI_W;

    logic [A_LO_W-1:0] w_a_lo;
    logic [A_HI_W-1:0] w_a_hi;
    logic [B_LO_W-1:0] w_b_lo;
    logic [B_HI_W-1:0] w_b_hi;

    assign w_a_lo = a[A_LO_W-1:0];
    assign w_a_hi = a[A_W-1:A_LO_W];
    assign w_b_lo = b[B_LO_W-1:0];
    assign w_b_hi = b[B_W-1:B_LO_W];

    (* use_dsp = "yes" *) logic [PLL_W-1:0] r_pll;
    (* use_dsp = "yes" *) logic [PLH_W-1:0] r_plh;
    (* use_dsp = "no"  *) logic [PHL_W-1:0] r_phl;
    (* use_dsp = "no"  *) logic [PHH_W-1:0] r_phh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pll <= '0;
            r_plh <= '0;
            r_phl <= '0;
            r_phh <= '0;
        end else if (en) begin
            r_pll <= PLL_W'(w_a_lo) * PLL_W'(w_b_lo);
            r_plh <= PLH_W'(w_a_lo) * PLH_W'(w_b_hi);
            r_phl <= PHL_W'(w_a_hi) * PHL_W'(w_b_lo);
            r_phh <= PHH_W'(w_a_hi) * PHH_W'(w_b_hi);
        end
    end

    assign pll = r_pll;
    assign plh = r_plh;
    assign phl = r_phl;
    assign phh = r_phh;

endmodule

`default_nettype wire

// File: rtl/hibrid_mul_pipe.sv
// ============================================================================
// Module      : hibrid_mul_pipe
// Description : 3-stage valid/ready unsigned multiplier with tag pass-through.
//               Define HIBRID_MUL_ACC_EN to add an S3 accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hibrid_mul_pipe
    import hibrid_mul_pkg::*;
#(
    parameter int A_W    = A_W_DEF,
    parameter int B_W    = B_W_DEF,
    parameter int A_LO_W = A_LO_W_DEF,
    parameter int B_LO_W = B_LO_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int ACC_W  = A_W + B_W + ACC_GUARD_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [A_W-1:0]                       in_a,
    input  logic [B_W-1:0]                       in_b,
    input  logic [TAG_W-1:0]                     in_tag,
    input  logic                                 in_acc,
    input  logic                                 in_clr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [res_w(A_W, B_W, ACC_W)-1:0]    out_p,
    output logic [TAG_W-1:0]                     out_tag
);

    localparam int RES_W  = res_w(A_W, B_W, ACC_W);
    localparam int PROD_W = A_W + B_W;
    localparam int PLL_W  = A_LO_W + B_LO_W;
    localparam int PLH_W  = A_LO_W + B_W - B_LO_W;
    localparam int PHL_W  = A_W - A_LO_W + B_LO_W;
    localparam int PHH_W  = A_W - A_LO_W + B_W - B_LO_W;

    logic w_adv;
    logic r_v1, r_v2, r_v3;
    logic [A_W-1:0]   r_a1;
    logic [B_W-1:0]   r_b1;
    logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
    logic [RES_W-1:0] r_p3;
    logic [RES_W-1:0] w_res;
    logic [PROD_W-1:0] w_prod;
    logic [PLL_W-1:0] w_pll;
    logic [PLH_W-1:0] w_plh;
    logic [PHL_W-1:0] w_phl;
    logic [PHH_W-1:0] w_phh;

    // Only a stalled, valid S3 beat blocks the pipe; bubbles always advance.
    assign w_adv     = !(r_v3 && !out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out_p     = r_p3;
    assign out_tag   = r_tag3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_tag3 <= '0;
            r_p3   <= '0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_a1   <= in_a;
            r_b1   <= in_b;
            r_tag1 <= in_tag;
            r_v2   <= r_v1;
            r_tag2 <= r_tag1;
            r_v3   <= r_v2;
            if (r_v2) begin
                r_p3   <= w_res;
                r_tag3 <= r_tag2;
            end
        end
    end

    hibrid_mul_pp #(
        .A_W    (A_W),
        .B_W    (B_W),
        .A_LO_W (A_LO_W),
        .B_LO_W (B_LO_W)
    ) u_pp (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_adv),
        .a     (r_a1),
        .b     (r_b1),
        .pll   (w_pll),
        .plh   (w_plh),
        .phl   (w_phl),
        .phh   (w_phh)
    );

    assign w_prod = PROD_W'(w_pll)
                  + (PROD_W'(w_plh) << B_LO_W)
                  + (PROD_W'(w_phl) << A_LO_W)
                  + (PROD_W'(w_phh) << (A_LO_W + B_LO_W));

`ifdef HIBRID_MUL_ACC_EN
    logic             r_acc1, r_clr1, r_acc2, r_clr2;
    logic [ACC_W-1:0] r_accum;
    logic [ACC_W-1:0] w_acc_sum;

    assign w_acc_sum = (r_clr2 ? '0 : r_accum) + ACC_W'(w_prod);
    assign w_res     = r_acc2 ? w_acc_sum : ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc1  <= 1'b0;
            r_clr1  <= 1'b0;
            r_acc2  <= 1'b0;
            r_clr2  <= 1'b0;
            r_accum <= '0;
        end else if (w_adv) begin
            r_acc1 <= in_acc;
            r_clr1 <= in_clr;
            r_acc2 <= r_acc1;
            r_clr2 <= r_clr1;
            if (r_v2 && r_acc2) begin
                r_accum <= w_acc_sum;
            end
        end
    end
`else
    logic w_unused_acc;

    assign w_unused_acc = in_acc ^ in_clr;
    assign w_res        = w_prod;
`endif

endmodule

`default_nettype wire
